sha256_stream_padder: RTL and testbench
=======================================

# sha256_stream_padder

Streaming SHA-256 message padder: accepts a message of arbitrary length as a sequence of IN_W-bit beats and emits the fully padded 512-bit blocks (message, 0x80 marker, zero fill, 64-bit big-endian bit length) to the message scheduler with a valid/ready handshake. It generalises the fixed 128-bit single-block pre-processing stage to multi-block messages, configurable beat width and byte-granular message length. It sits between the FSB input and the message scheduler.

## Interface
- IN_W, 32: input beat width in bits; must be 32, 64 or 128 (divides 512).
- LEN_W, 64: internal bit-length counter width (≤64); zero-extended into the 64-bit length field.
- clk_i  input  1  clock; single clock domain.
- reset_i  input  1  asynchronous, active-high reset.
- data_i  input  IN_W  message beat; first byte of the beat in data_i[IN_W-1 -: 8].
- v_i  input  1  data_i valid.
- last_i  input  1  beat is the final beat of the message.
- last_bytes_i  input  $clog2(IN_W/8)+1  valid bytes in the last beat, 1..IN_W/8 (used only with SHA256_PAD_BYTE_EN).
- ready_o  output  1  padder accepts a beat this cycle.
- block_o  output  512  padded block; message byte 0 in block_o[511:504].
- v_o  output  1  block_o valid.
- last_o  output  1  block_o is the final block of the message.
- ready_i  input  1  scheduler accepts block_o.

## Operation
- Beat accepted when v_i & ready_o; block accepted when v_o & ready_i.
- States: S_FILL, S_SEND, S_EXTRA, S_SEND_LAST.
- S_FILL: ready_o=1. Beat k written to block buffer at bits [511-k*IN_W -: IN_W]; beat index cnt increments; bit counter len += 8*valid_bytes (mod 2^LEN_W).
  - Non-last beat completing the buffer (cnt==512/IN_W-1) -> S_SEND, last flag 0.
  - Last beat: bytes after the final valid byte are cleared; 0x80 written at byte position p = byte offset of message end within block, if p<64.
    - p≤55: length (including this beat) written to bytes 56..63 -> S_SEND_LAST.
    - 56≤p≤63: -> S_SEND, then S_EXTRA.
    - p==64 (message ends exactly on block boundary): -> S_SEND with pend80 set, then S_EXTRA.
- S_SEND: ready_o=0, v_o=1; on ready_i buffer cleared, cnt=0 -> S_FILL, or S_EXTRA if the message is finished.
- S_EXTRA: one internal cycle builds the zero block with length in bytes 56..63 and 0x80 at byte 0 if pend80 -> S_SEND_LAST.
- S_SEND_LAST: v_o=1, last_o=1; on ready_i len, cnt, pend80, buffer cleared -> S_FILL.
- v_i while ready_o=0 is held by the producer (no drop). Zero-length messages are not supported.

## Timing
- Reset values: v_o=0, last_o=0, block_o=0, state S_FILL, len=0, cnt=0; ready_o=1 in the first cycle after reset deasserts.
- Block presented (registered) the cycle after the beat completing it. One cycle of ready_o=0 minimum per block (S_SEND handshake); S_EXTRA adds one cycle before the extra block.
- block_o, v_o, last_o stable while v_o=1 & ready_i=0.
- Reset asserted mid-message: partial block and length discarded immediately; no partial block emitted afterwards.
- len wraps modulo 2^LEN_W without error indication.

## Configuration
- SHA256_PAD_BYTE_EN defined: last_bytes_i honoured; length and 0x80 position byte-granular.
- Undefined: last_bytes_i ignored; every beat treated as fully valid (messages are multiples of IN_W bits); byte-mask logic removed.

## Structure
- sha256_pkg: SHA256_BLOCK_W=512, SHA256_LEN_FIELD_W=64, SHA256_LEN_OFFSET=56 (byte), padder state enum.
- Sub-module sha256_pad_insert: combinational; given buffer, byte end position, length and mode, returns the block with masking, 0x80 and length field applied. FSM, counters and handshake stay in sha256_stream_padder.

## Test plan
- IN_W=32, byte mode, "abc": one beat 0x61626300, last_bytes_i=3 -> one block 0x61626380, 0…0, last word 0x00000018, last_o=1.
- 14 full beats (56 bytes), last on beat 14 -> block 1: message bytes then 0x80 at byte 56, zeros, last_o=0; block 2: zeros, length 0x1C0, last_o=1.
- 16 full beats (64 bytes) -> block 1: message only; block 2: 0x80000000, zeros, length 0x200, last_o=1.
- ready_i held low 5 cycles with v_o=1 -> block_o stable, ready_o=0, no beat accepted; release -> one transfer.
- reset_i pulsed after beat 7 of a message -> v_o=0; new "abc" message yields exactly the single-block result above.
- SHA256_PAD_BYTE_EN undefined, last_bytes_i=1 on a single beat 0x61626364 -> length 0x20, 0x80 at byte 4.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared constants and types for the SHA-256 front end.
//   SHA256_BLOCK_W      : width of one padded message block (bits)
//   SHA256_LEN_FIELD_W  : width of the trailing big-endian bit-length field
//   SHA256_LEN_OFFSET   : byte position where the length field starts
//   pad_state_t         : padder FSM states
//   pad_mode_t          : selects how sha256_pad_insert finishes a block
package sha256_pkg;

  localparam int SHA256_BLOCK_W     = 512;
  localparam int SHA256_LEN_FIELD_W = 64;
  localparam int SHA256_LEN_OFFSET  = 56;
  localparam int SHA256_BLOCK_BYTES = SHA256_BLOCK_W / 8;

  typedef enum logic [1:0] {
    S_FILL      = 2'd0,
    S_SEND      = 2'd1,
    S_EXTRA     = 2'd2,
    S_SEND_LAST = 2'd3
  } pad_state_t;

  // PAD_LAST : block holding the end of the message (length only if it fits)
  // PAD_EXTRA: additional trailing block (length always written)
  typedef enum logic {
    PAD_LAST  = 1'b0,
    PAD_EXTRA = 1'b1
  } pad_mode_t;

endpackage

// File: rtl/sha256_pad_insert.sv
// sha256_pad_insert
// Combinational finishing of a padded block: bytes after the message end are
// cleared, the 0x80 marker is placed at the end position (when it lies inside
// the block) and the 64-bit length is written to bytes 56..63 when it fits
// (PAD_LAST) or unconditionally (PAD_EXTRA).
// Ports:
//   raw_block    : buffered block, message byte 0 in [511:504]
//   end_pos      : byte offset of the message end within the block, 0..64
//   bit_len      : message length in bits, big-endian field value
//   mode         : PAD_LAST / PAD_EXTRA
//   padded_block : finished block
module sha256_pad_insert
  import sha256_pkg::*;
(
  input  logic [SHA256_BLOCK_W-1:0]     raw_block,
  input  logic [6:0]                    end_pos,
  input  logic [SHA256_LEN_FIELD_W-1:0] bit_len,
  input  pad_mode_t                     mode,
  output logic [SHA256_BLOCK_W-1:0]     padded_block
);

  logic len_en_s;

  // Length goes in this block only if the marker left room for it.
  assign len_en_s = (mode == PAD_EXTRA) || (end_pos < 7'(SHA256_LEN_OFFSET));

  // Per-byte keep / marker / clear, then optional length overlay.
  always_comb begin
    padded_block = raw_block;
    for (int i = 0; i < SHA256_BLOCK_BYTES; i++) begin
      padded_block[SHA256_BLOCK_W-1-8*i -: 8] =
        (7'(i) < end_pos)  ? raw_block[SHA256_BLOCK_W-1-8*i -: 8] :
        (7'(i) == end_pos) ? 8'h80 : 8'h00;
    end
    padded_block[SHA256_LEN_FIELD_W-1:0] =
      len_en_s ? bit_len : padded_block[SHA256_LEN_FIELD_W-1:0];
  end

endmodule

// File: rtl/sha256_stream_padder.sv
// sha256_stream_padder
// Streaming SHA-256 padder: collects IN_W-bit message beats into 512-bit
// blocks and emits them fully padded (0x80 marker, zero fill, 64-bit
// big-endian bit length) over a valid/ready handshake.
// Optional feature macro: SHA256_PAD_BYTE_EN -- when defined, last_bytes_i
// gives the valid byte count of the final beat; otherwise every beat is full.
// Ports:
//   clk_i, reset_i (async, active-high)
//   data_i/v_i/last_i/last_bytes_i/ready_o : message beat input
//   block_o/v_o/last_o/ready_i             : padded block output
module sha256_stream_padder
  import sha256_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int LEN_W = 64
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [IN_W-1:0]           data_i,
  input  logic                      v_i,
  input  logic                      last_i,
  input  logic [$clog2(IN_W/8):0]   last_bytes_i,
  output logic                      ready_o,
  output logic [SHA256_BLOCK_W-1:0] block_o,
  output logic                      v_o,
  output logic                      last_o,
  input  logic                      ready_i
);

  localparam int BEAT_BYTES = IN_W / 8;
  localparam int BEATS      = SHA256_BLOCK_W / IN_W;
  localparam int CNT_W      = $clog2(BEATS);
  localparam int VB_W       = $clog2(BEAT_BYTES) + 1;

  pad_state_t                  state_r, state_nxt_s;
  logic [SHA256_BLOCK_W-1:0]   buf_r, buf_nxt_s, merged_s, padded_s, raw_s;
  logic [CNT_W-1:0]            cnt_r, cnt_nxt_s;
  logic [LEN_W-1:0]            len_r, len_nxt_s, len_add_s, len_sel_s;
  logic                        pend80_r, pend80_nxt_s;
  logic                        done_r, done_nxt_s;
  logic [VB_W-1:0]             valid_bytes_s;
  logic [6:0]                  end_pos_s, pad_pos_s;
  logic [8:0]                  base_s;
  pad_mode_t                   mode_s;

`ifdef SHA256_PAD_BYTE_EN
  assign valid_bytes_s = last_i ? last_bytes_i : VB_W'(BEAT_BYTES);
`else
  logic [VB_W-1:0] unused_last_bytes_s;
  assign unused_last_bytes_s = last_bytes_i;
  assign valid_bytes_s       = VB_W'(BEAT_BYTES);
`endif

  assign len_add_s = len_r + LEN_W'({valid_bytes_s, 3'b000});
  assign end_pos_s = 7'(cnt_r) * 7'(BEAT_BYTES) + 7'(valid_bytes_s);
  assign base_s    = 9'(SHA256_BLOCK_W - 1) - 9'(cnt_r) * 9'(IN_W);

  // Incoming beat dropped into its slot of the block buffer.
  always_comb begin
    merged_s                  = buf_r;
    merged_s[base_s -: IN_W]  = data_i;
  end

  // S_EXTRA pads the (already cleared) buffer; otherwise the beat being closed.
  assign mode_s    = (state_r == S_EXTRA) ? PAD_EXTRA : PAD_LAST;
  assign raw_s     = (state_r == S_EXTRA) ? buf_r : merged_s;
  assign pad_pos_s = (state_r == S_EXTRA) ? (pend80_r ? 7'd0 : 7'd64) : end_pos_s;
  assign len_sel_s = (state_r == S_EXTRA) ? len_r : len_add_s;

  sha256_pad_insert u_pad_insert (
    .raw_block    (raw_s),
    .end_pos      (pad_pos_s),
    .bit_len      (SHA256_LEN_FIELD_W'(len_sel_s)),
    .mode         (mode_s),
    .padded_block (padded_s)
  );

  // Next-state and datapath update for the padder FSM.
  always_comb begin
    state_nxt_s  = state_r;
    buf_nxt_s    = buf_r;
    cnt_nxt_s    = cnt_r;
    len_nxt_s    = len_r;
    pend80_nxt_s = pend80_r;
    done_nxt_s   = done_r;
    case (state_r)
      S_FILL: begin
        if (v_i) begin
          len_nxt_s = len_add_s;
          if (last_i) begin
            buf_nxt_s  = padded_s;
            done_nxt_s = 1'b1;
            if (end_pos_s < 7'(SHA256_LEN_OFFSET)) begin
              state_nxt_s = S_SEND_LAST;
            end else begin
              // No room for the length: it goes in an extra block, and the
              // marker too when the message filled this block exactly.
              state_nxt_s  = S_SEND;
              pend80_nxt_s = (end_pos_s == 7'(SHA256_BLOCK_BYTES));
            end
          end else begin
            buf_nxt_s = merged_s;
            cnt_nxt_s = cnt_r + CNT_W'(1);
            if (cnt_r == CNT_W'(BEATS - 1)) begin
              state_nxt_s = S_SEND;
            end else begin
              state_nxt_s = S_FILL;
            end
          end
        end else begin
          state_nxt_s = S_FILL;
        end
      end
      S_SEND: begin
        if (ready_i) begin
          buf_nxt_s   = '0;
          cnt_nxt_s   = '0;
          state_nxt_s = done_r ? S_EXTRA : S_FILL;
        end else begin
          state_nxt_s = S_SEND;
        end
      end
      S_EXTRA: begin
        buf_nxt_s   = padded_s;
        state_nxt_s = S_SEND_LAST;
      end
      S_SEND_LAST: begin
        if (ready_i) begin
          buf_nxt_s    = '0;
          cnt_nxt_s    = '0;
          len_nxt_s    = '0;
          pend80_nxt_s = 1'b0;
          done_nxt_s   = 1'b0;
          state_nxt_s  = S_FILL;
        end else begin
          state_nxt_s = S_SEND_LAST;
        end
      end
      default: begin
        state_nxt_s = S_FILL;
      end
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= S_FILL;
      ready_o <= 1'b1;
      v_o     <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_o <= (state_nxt_s == S_FILL);
      v_o     <= (state_nxt_s == S_SEND) || (state_nxt_s == S_SEND_LAST);
      last_o  <= (state_nxt_s == S_SEND_LAST);
    end
  end

  // Block buffer, beat index, bit length and padding flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      buf_r    <= '0;
      cnt_r    <= '0;
      len_r    <= '0;
      pend80_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      buf_r    <= buf_nxt_s;
      cnt_r    <= cnt_nxt_s;
      len_r    <= len_nxt_s;
      pend80_r <= pend80_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  assign block_o = buf_r;

endmodule

// File: tb/tb_sha256_stream_padder.sv
// tb_sha256_stream_padder
// Random-stimulus bench: messages are streamed into the padder and every
// emitted block is compared with blocks produced by a byte-level SHA-256
// padding model (append 0x80, zero-fill to 56 mod 64, append bit length).
module tb_sha256_stream_padder;

  localparam int IN_W = 32;
  localparam int BB   = IN_W / 8;
  localparam int VB_W = $clog2(BB) + 1;

  logic             clk = 1'b0;
  logic             reset_i;
  logic [IN_W-1:0]  data_i;
  logic             v_i, last_i, ready_i;
  logic [VB_W-1:0]  last_bytes_i;
  logic             ready_o, v_o, last_o;
  logic [511:0]     block_o;

  sha256_stream_padder #(.IN_W(IN_W), .LEN_W(64)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .data_i       (data_i),
    .v_i          (v_i),
    .last_i       (last_i),
    .last_bytes_i (last_bytes_i),
    .ready_o      (ready_o),
    .block_o      (block_o),
    .v_o          (v_o),
    .last_o       (last_o),
    .ready_i      (ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  byte unsigned msg[$];
  logic [511:0] exp_q[$];
  bit           exp_last_q[$];
  logic [511:0] last_blk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference padding of the whole message at byte level.
  task automatic build_expected();
    byte unsigned pad[$];
    logic [63:0]  bitlen;
    logic [511:0] blk;
    int           nblk;
    pad = msg;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bitlen = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) pad.push_back(bitlen[8*i +: 8]);
    nblk = pad.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pad[64*b+j];
      exp_q.push_back(blk);
      exp_last_q.push_back(b == nblk - 1);
    end
  endtask

  task automatic fill_random(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  // Streams msg; stall = cycles ready_i is forced low while v_o is high;
  // abort_beats > 0 stops after that many accepted beats (no draining).
  task automatic run_msg(input int vpct, input int rpct, input int stall, input int abort_beats);
    int           nbeats, beat, cyc, stall_left, idx;
    logic [511:0] held;
    bit           hold_chk;
    nbeats = (msg.size() + BB - 1) / BB;
    exp_q.delete();
    exp_last_q.delete();
    build_expected();
    beat = 0; cyc = 0; stall_left = stall; hold_chk = 1'b0; held = '0;
    while ((beat < nbeats || exp_q.size() > 0) && cyc < 3000) begin
      if (abort_beats > 0 && beat == abort_beats) break;
      v_i    = (beat < nbeats) && ($urandom_range(0, 99) < vpct);
      last_i = (beat == nbeats - 1);
      for (int k = 0; k < BB; k++) begin
        idx = beat * BB + k;
        if (idx < msg.size()) data_i[IN_W-1-8*k -: 8] = msg[idx];
        else                  data_i[IN_W-1-8*k -: 8] = 8'($urandom);
      end
`ifdef SHA256_PAD_BYTE_EN
      last_bytes_i = last_i ? VB_W'(msg.size() - beat * BB) : VB_W'($urandom);
`else
      last_bytes_i = VB_W'($urandom_range(0, BB));
`endif
      if (stall_left > 0 && v_o) begin
        ready_i = 1'b0;
        stall_left--;
      end else begin
        ready_i = ($urandom_range(0, 99) < rpct);
      end
      #1;
      if (hold_chk) begin
        check("hold_v_o", v_o, 1'b1);
        check("hold_block", block_o, held);
      end
      if (v_o) check("ready_low_while_valid", ready_o, 1'b0);
      if (v_o && ready_i) begin
        check("block_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          last_blk = block_o;
          check("block", block_o, exp_q.pop_front());
          check("last_o", last_o, exp_last_q.pop_front());
        end
      end
      hold_chk = v_o && !ready_i;
      held     = block_o;
      if (v_i && ready_o) beat++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    v_i = 1'b0;
    last_i = 1'b0;
    ready_i = 1'b0;
    if (abort_beats == 0) begin
      check("drain_done", (beat == nbeats) && (exp_q.size() == 0), 1'b1);
      #1;
      check("idle_v_o", v_o, 1'b0);
    end
  endtask

  logic [511:0] short_exp;
  int           n;
  int           edge_len[7] = '{52, 56, 60, 64, 116, 120, 128};

  initial begin
    reset_i = 1'b1; v_i = 1'b0; last_i = 1'b0; data_i = '0;
    last_bytes_i = '0; ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    check("reset_v_o", v_o, 1'b0);
    check("reset_last_o", last_o, 1'b0);
    check("reset_block_o", block_o, 512'd0);
    check("reset_ready_o", ready_o, 1'b1);
    @(negedge clk);

    // Short single-beat message with a known constant result.
    short_exp = '0;
`ifdef SHA256_PAD_BYTE_EN
    msg = '{8'h61, 8'h62, 8'h63};
    short_exp[511:480] = 32'h61626380;
    short_exp[31:0]    = 32'h00000018;
`else
    msg = '{8'h61, 8'h62, 8'h63, 8'h64};
    short_exp[511:480] = 32'h61626364;
    short_exp[479:448] = 32'h80000000;
    short_exp[31:0]    = 32'h00000020;
`endif
    run_msg(100, 100, 0, 0);
    check("short_const", last_blk, short_exp);

    // Lengths around the 56-byte and 64-byte boundaries.
    foreach (edge_len[i]) begin
      fill_random(edge_len[i]);
      run_msg(100, 100, 0, 0);
    end

    // Output held off for five cycles while a block is valid.
    fill_random(64);
    run_msg(100, 100, 5, 0);

    // Reset in the middle of a message, then the short message again.
    fill_random(64);
    run_msg(100, 100, 0, 7);
    reset_i = 1'b1;
    #1;
    check("midreset_v_o", v_o, 1'b0);
    check("midreset_block_o", block_o, 512'd0);
    check("midreset_ready_o", ready_o, 1'b1);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
`ifdef SHA256_PAD_BYTE_EN
    msg = '{8'h61, 8'h62, 8'h63};
`else
    msg = '{8'h61, 8'h62, 8'h63, 8'h64};
`endif
    run_msg(100, 100, 0, 0);
    check("post_reset_short_const", last_blk, short_exp);

    // Random lengths, gaps and back-pressure.
    for (int t = 0; t < 25; t++) begin
`ifdef SHA256_PAD_BYTE_EN
      n = $urandom_range(1, 200);
`else
      n = BB * $urandom_range(1, 50);
`endif
      fill_random(n);
      run_msg($urandom_range(40, 100), $urandom_range(30, 100), $urandom_range(0, 3), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
